// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD controller state names, 50 MHz timing defaults and delay-load helper
package lcd_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, E_HI1, GAP, E_HI2, HOLD} lcd_state_t;
  localparam int LCD_SETUP_CYC  = 2;
  localparam int LCD_E_HIGH_CYC = 12;
  localparam int LCD_E_GAP_CYC  = 50;
  localparam int LCD_POLL_MAX   = 1023;
  // A phase lasting n cycles loads n-1 so it ends on the cycle the counter reads zero.
  function automatic logic [7:0] delay_load(input int n);
    return 8'(n - 1);
  endfunction
endpackage

// File: rtl/lcd_reader_if.sv
// lcd_reader_if: read request/response handshake plus LCD pin group.
//   master: host/board side (drives rd_req, rd_rs, sf_d_in)
//   slave : lcd_reader (drives busy, rd_valid, rd_data, rd_timeout, lcd_e, lcd_rs, lcd_rw)
interface lcd_reader_if;
  logic       rd_req;
  logic       rd_rs;
  logic       busy;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_timeout;
  logic [3:0] sf_d_in;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  modport master (
    output rd_req, rd_rs, sf_d_in,
    input  busy, rd_valid, rd_data, rd_timeout, lcd_e, lcd_rs, lcd_rw
  );
  modport slave (
    input  rd_req, rd_rs, sf_d_in,
    output busy, rd_valid, rd_data, rd_timeout, lcd_e, lcd_rs, lcd_rw
  );
endinterface

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: loadable 8-bit down-counter, done while the count is zero.
//   clk, reset (async, active-low), load, load_val[7:0] -> done
module lcd_delay_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);
  logic [7:0] cnt;
  assign done = cnt == 8'd0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= 8'd0;
    else if (load) cnt <= load_val;
    else if (!done) cnt <= cnt - 8'd1;
endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: 4-bit HD44780 read controller, one byte as two timed E strobes with RW high.
//   clk, reset (async, active-low), bus (lcd_reader_if.slave):
//   rd_req/rd_rs in, busy/rd_valid/rd_data/rd_timeout out, sf_d_in in, lcd_e/lcd_rs/lcd_rw out.
//   Macro LCD_READER_BF_POLL_EN: RS=0 reads re-read while the busy flag is set, up to POLL_MAX times.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC  = LCD_SETUP_CYC,
  parameter int E_HIGH_CYC = LCD_E_HIGH_CYC,
  parameter int E_GAP_CYC  = LCD_E_GAP_CYC,
  parameter int POLL_MAX   = LCD_POLL_MAX
) (
  input logic         clk,
  input logic         reset,
  lcd_reader_if.slave bus
);
  lcd_state_t state;
  logic [3:0] nib_hi, nib_lo;
  logic       load, done;
  logic [7:0] load_val;
  if (SETUP_CYC < 1 || SETUP_CYC > 255 || E_HIGH_CYC < 1 || E_HIGH_CYC > 255 ||
      E_GAP_CYC < 1 || E_GAP_CYC > 255 || POLL_MAX < 1) begin : g_param_chk
    $error("lcd_reader: delay constants must be 1..255 and POLL_MAX >= 1");
  end
  // The counter is reloaded on every phase exit with the length of the phase that follows.
  assign load = state == IDLE || done;
  always_comb
    load_val = state == IDLE                   ? delay_load(SETUP_CYC) :
               state == E_HI1 || state == HOLD ? delay_load(E_GAP_CYC) :
               state == E_HI2                  ? 8'd0 : delay_load(E_HIGH_CYC);
  lcd_delay_cnt u_dly (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );
`ifdef LCD_READER_BF_POLL_EN
  localparam int PW = $clog2(POLL_MAX + 1);
  logic [PW-1:0] poll_cnt;
  logic          repoll, timeout, bf_set;
  assign bf_set = !bus.lcd_rs && nib_hi[3];
  assign bus.rd_timeout = timeout;
`else
  assign bus.rd_timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      bus.lcd_e    <= 1'b0;
      bus.lcd_rw   <= 1'b0;
      bus.lcd_rs   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= 8'h00;
      nib_hi       <= 4'h0;
      nib_lo       <= 4'h0;
`ifdef LCD_READER_BF_POLL_EN
      poll_cnt     <= '0;
      repoll       <= 1'b0;
      timeout      <= 1'b0;
`endif
    end else begin
      bus.rd_valid <= 1'b0;
`ifdef LCD_READER_BF_POLL_EN
      timeout      <= 1'b0;
`endif
      case (state)
        IDLE: if (bus.rd_req) begin
          state      <= SETUP;
          bus.busy   <= 1'b1;
          bus.lcd_rw <= 1'b1;
          bus.lcd_rs <= bus.rd_rs;
        end
        SETUP: if (done) begin
          state     <= E_HI1;
          bus.lcd_e <= 1'b1;
        end
        E_HI1: if (done) begin
          state     <= GAP;
          bus.lcd_e <= 1'b0;
          nib_hi    <= bus.sf_d_in;
        end
        GAP: if (done) begin
`ifdef LCD_READER_BF_POLL_EN
          state     <= repoll ? E_HI1 : E_HI2;
          repoll    <= 1'b0;
`else
          state     <= E_HI2;
`endif
          bus.lcd_e <= 1'b1;
        end
        E_HI2: if (done) begin
          state     <= HOLD;
          bus.lcd_e <= 1'b0;
          nib_lo    <= bus.sf_d_in;
        end
        HOLD: begin
`ifdef LCD_READER_BF_POLL_EN
          if (bf_set && poll_cnt != PW'(POLL_MAX)) begin
            state    <= GAP;
            repoll   <= 1'b1;
            poll_cnt <= poll_cnt + 1'b1;
          end else begin
            timeout  <= bf_set;
            poll_cnt <= '0;
`else
          begin
`endif
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.lcd_rw   <= 1'b0;
            bus.lcd_rs   <= 1'b0;
            bus.rd_valid <= 1'b1;
            bus.rd_data  <= {nib_hi, nib_lo};
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/lcd_reader.md
# lcd_reader

Read-side companion to the team's LCD write controller on the 4-bit HD44780-style character LCD interface (SF_D[11:8], LCD_E, LCD_RS, LCD_RW). On request it performs one 8-bit read as two timed nibble strobes with RW high. With RS=0 it returns busy flag and address; with RS=1 it returns DDRAM/CGRAM data. It sits beside the write controller under the board top level, and the top level muxes the LCD control pins and tristates SF_D toward the reader while `busy` is high.

## Interface
Parameters:
- SETUP_CYC, 2: cycles RS/RW are stable before the first E rise (≥40 ns at 50 MHz).
- E_HIGH_CYC, 12: cycles E is high per nibble (≥230 ns).
- E_GAP_CYC, 50: cycles E is low between nibbles (1 µs).
- POLL_MAX, 1023: maximum re-reads in busy-poll mode.
- Delay constants must be 1..255; the delay counter is 8 bits.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request; sampled only when busy=0.
- rd_rs  in  1  register select for the request, latched on accept.
- busy  out  1  reader owns the LCD bus; high from the cycle after accept through HOLD.
- rd_valid  out  1  one-cycle pulse: rd_data is updated.
- rd_data  out  8  last byte read; holds its value until the next read.
- rd_timeout  out  1  one-cycle pulse with rd_valid when busy-poll is exhausted.
- sf_d_in  in  4  SF_D[11:8] input path.
- lcd_e  out  1  enable strobe.
- lcd_rs  out  1  register select.
- lcd_rw  out  1  1 = read.

## Operation
- States: IDLE, SETUP, E_HI1, GAP, E_HI2, HOLD.
- IDLE: outputs lcd_e=0, lcd_rw=0, lcd_rs=0, busy=0. If rd_req=1 at a clock edge, latch rd_rs and go to SETUP.
- SETUP (SETUP_CYC cycles): lcd_rw=1, lcd_rs=latched value, lcd_e=0.
- E_HI1 (E_HIGH_CYC cycles): lcd_e=1. sf_d_in is sampled into rd_data[7:4] on the last cycle, i.e. the edge that drops E.
- GAP (E_GAP_CYC cycles): lcd_e=0.
- E_HI2 (E_HIGH_CYC cycles): lcd_e=1. sf_d_in is sampled into rd_data[3:0] on the last cycle.
- HOLD (1 cycle): lcd_e=0, RS and RW held. Go to IDLE and pulse rd_valid.
- lcd_rw and lcd_rs stay constant for the whole SETUP→HOLD window.
- rd_req while busy=1 is ignored; there is no queue.
- rd_req held high across rd_valid starts a new read in the rd_valid cycle.
- The reader never drives SF_D.

## Timing
- Reset values: lcd_e=0, lcd_rw=0, lcd_rs=0, busy=0, rd_valid=0, rd_timeout=0, rd_data=8'h00, state IDLE.
- Reset asserted mid-read aborts at once with the same values. No rd_valid is produced.
- Accept edge = cycle 0. busy is high for cycles 1..(SETUP_CYC+2·E_HIGH_CYC+E_GAP_CYC+1).
- rd_valid fires in the next cycle, at the same time busy falls. With default parameters: busy covers cycles 1..77 and rd_valid is at cycle 78.
- Sampled nibbles are registered, so rd_data changes on the edge that enters the rd_valid cycle.

## Configuration
- Macro LCD_READER_BF_POLL_EN.
- Defined: an RS=0 read whose result has bit 7 = 1 does not complete at HOLD. Instead it goes to GAP (E_GAP_CYC cycles) and then back to E_HI1, repeating the two-nibble read with RW/RS held.
  - The poll counter ($clog2(POLL_MAX+1) bits) increments per re-read.
  - The read completes with rd_valid when bit 7 = 0.
  - After POLL_MAX re-reads it completes with rd_valid and rd_timeout both pulsed, and rd_data shows the last busy value.
  - RS=1 reads never poll.
- Not defined: every read is single-shot, rd_timeout is tied 0, and no poll counter exists.

## Structure
- Shared package lcd_pkg: the state enum (shared naming with the write controller) and default timing constants for 50 MHz.
- One sub-module, lcd_delay_cnt: a loadable 8-bit down-counter with a `done` flag. It is reused by the write controller.
- The FSM and nibble capture stay in lcd_reader.

## Test plan
- Reset: assert reset mid-E_HI1 → lcd_e=0, lcd_rw=0, busy=0 in the same cycle; no rd_valid.
- RS=1 read: model drives sf_d_in=4'hA during E_HI1 and 4'h5 during E_HI2; rd_req at cycle 0 → rd_valid at cycle 78, rd_data=8'hA5, lcd_rs=1 throughout, E high exactly 12 cycles twice with a 50-cycle gap.
- Ignored request: rd_req pulsed at cycle 20 during busy → no second transaction; exactly one rd_valid.
- Back-to-back: rd_req held high → second SETUP starts in the rd_valid cycle; second rd_valid at cycle 156.
- BF poll (macro on): rd_rs=0, model returns 8'h83 three times, then 8'h03 → three extra nibble pairs, one rd_valid, rd_data=8'h03, rd_timeout=0.
- Timeout (macro on, POLL_MAX=4): model always returns 8'h80 → rd_valid and rd_timeout in the same cycle after 5 total reads, rd_data=8'h80. With the macro off, the same stimulus gives a single read with rd_data=8'h80 and rd_timeout=0.
